sar_afe_emulator: RTL and testbench
===================================

Name: sar_afe_emulator

Overview:
Digital twin of the SAR ADC analog front end, covering the bootstrap switch, the capacitive DAC and the clocked comparator. It is the responder to the SAR controller: it consumes s_clk, cmp_clk, the trial code and eoc, and returns cmp_out. It is used for FPGA prototyping and closed-loop verification of the controller. It also monitors protocol sequencing and checks each final code against the held input.

Parameters:
OFFSET, 0, signed comparator input offset in LSB, range -8..+7
CNT_W, 16, width of conv_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
vin  in  8  emulated analog input, as an unsigned code
s_clk  in  1  bootstrap switch control; high = track
cmp_clk  in  1  comparator clock; high = evaluate
dac_code  in  8  current trial/SAR code driving the DAC
eoc  in  1  end-of-conversion pulse from the controller
clr_err  in  1  clears the sticky error flags
cmp_out  out  1  comparator decision
held_code  out  8  sampled input code
conv_done  out  1  one-cycle pulse when a conversion is checked
conv_ok  out  1  result of the last check; valid from conv_done onward
conv_count  out  CNT_W  number of conversions that passed the check
err_seq  out  1  sticky protocol-sequence error
err_mismatch  out  1  sticky final-code mismatch

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk. All outputs and internal registers reset to 0; state resets to S_IDLE.
- Effective input: vin_eff = s_clk ? vin : held_code. The switch is closed while s_clk is high.
- Comparator arithmetic is 10-bit signed: cmp_q <= (vin_eff + OFFSET + noise) >= dac_code. cmp_q registers every cycle (1-cycle latency); noise is 0 unless the optional feature is enabled.
- cmp_out = cmp_clk ? cmp_q : 0. This is a reset-phase comparator; the decision is valid in the cycle cmp_clk is high.
- expected = clamp(held_code + OFFSET, 0, 255).
- Edge detection: s_clk and cmp_clk are delayed one cycle to form rise and fall strobes.

State machine:
- S_IDLE:
  - s_clk rise -> S_TRACK.
  - cmp_clk rise or eoc -> set err_seq; stay in S_IDLE.
- S_TRACK:
  - s_clk fall -> capture held_code <= vin, clear cmp_cnt, go to S_HOLD.
  - cmp_clk rise while tracking -> set err_seq.
- S_HOLD:
  - Each cmp_clk rise increments cmp_cnt (4 bits, saturating at 15).
  - A 9th cmp_clk rise sets err_seq.
  - eoc with cmp_cnt == 8 -> go to S_CHECK.
  - eoc with cmp_cnt != 8 -> set err_seq; go to S_IDLE.
  - s_clk rise -> set err_seq; abort, go to S_TRACK.
- S_CHECK (one cycle):
  - Compare dac_code with expected.
  - Pulse conv_done; conv_ok = match.
  - On match, increment conv_count, wrapping modulo 2^CNT_W.
  - On mismatch, set err_mismatch.
  - Go to S_IDLE; if s_clk rises in this same cycle, go to S_TRACK instead.

Simultaneous events and clearing:
- Priority: rst > s_clk rise > eoc > cmp_clk rise.
- clr_err clears both sticky flags. A new error raised in the same cycle as clr_err wins, so the flag stays set.
- Reset mid-conversion returns to S_IDLE with no conv_done and no error.

Optional Feature:
AFE_NOISE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on rst) advances every clk.
  - noise is taken from lfsr[1:0]: 00 -> -1, 11 -> +1, otherwise 0.
  - The check tolerance becomes |dac_code - expected| <= 1.
- Undefined: noise = 0, the check requires an exact match, and no LFSR logic is present.

Decomposition:
- Package sar_pkg holds:
  - the state enum for S_IDLE/S_TRACK/S_HOLD/S_CHECK;
  - the constant SAR_BITS = 8;
  - the constant LFSR_SEED = 16'hACE1.
- One natural sub-module, sar_noise_lfsr, instantiated only under AFE_NOISE_EN.

Test Plan:
- Closed loop with the SAR controller, vin=8'hA5, cnvst pulse:
  - exactly 8 cmp_clk pulses;
  - final code 8'hA5;
  - conv_done pulse with conv_ok=1;
  - conv_count=1; no errors.
- Boundaries with vin=8'h00 then 8'hFF: codes 8'h00 and 8'hFF, both conv_ok=1, conv_count=2.
- OFFSET=3, vin=8'hFE: expected clamps to 8'hFF; final code 8'hFF; conv_ok=1.
- cmp_clk pulsed in S_IDLE: err_seq=1. Then clr_err: err_seq=0.
- s_clk re-asserted after 4 cmp_clk pulses: err_seq=1, state S_TRACK, no conv_done. Next full conversion passes.
- dac_code forced to 8'h00 during the eoc cycle with held_code=8'h40: conv_ok=0, err_mismatch=1, conv_count unchanged. Then rst asserted mid-conversion: all outputs 0.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR analog front-end emulator.
package sar_pkg;

  localparam int SAR_BITS = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Conversion sequencing as seen from the front end.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/sar_noise_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the comparator noise source.
// Only instantiated when AFE_NOISE_EN is defined.
module sar_noise_lfsr
  import sar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] noise_bits
);

  logic [15:0] lfsr;
  logic        feedback;

  assign feedback   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign noise_bits = lfsr[1:0];

  // Advance every clock; reseed on reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], feedback};
  end

endmodule

// File: rtl/sar_afe_emulator.sv
// Digital twin of the SAR ADC front end: bootstrap switch, capacitive DAC and
// clocked comparator, plus a protocol monitor and final-code checker.
// Optional build macro AFE_NOISE_EN adds LFSR comparator noise and relaxes the
// final-code check to a +/-1 LSB tolerance.
//
// Result signalling: conv_done is a one-cycle strobe; conv_ok carries the
// outcome of that check and holds it until the next check. There is no
// backpressure -- the controller drives s_clk/cmp_clk/eoc and this block
// only responds.
module sar_afe_emulator
  import sar_pkg::*;
#(
  parameter int OFFSET = 0,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAR_BITS-1:0] vin,
  input  logic                s_clk,
  input  logic                cmp_clk,
  input  logic [SAR_BITS-1:0] dac_code,
  input  logic                eoc,
  input  logic                clr_err,
  output logic                cmp_out,
  output logic [SAR_BITS-1:0] held_code,
  output logic                conv_done,
  output logic                conv_ok,
  output logic [CNT_W-1:0]    conv_count,
  output logic                err_seq,
  output logic                err_mismatch,
  output state_t              state
);

  localparam logic signed [9:0] OFFSET_S = 10'(OFFSET);

  logic                s_d, cmp_d, cmp_q;
  logic [3:0]          cmp_cnt;
  logic                s_rise, s_fall, cmp_rise;
  logic [SAR_BITS-1:0] vin_eff, expected;
  logic signed [9:0]   noise, cmp_lhs, exp_sum;
  logic                match;

  assign s_rise   = s_clk & ~s_d;
  assign s_fall   = ~s_clk & s_d;
  assign cmp_rise = cmp_clk & ~cmp_d;

  // Switch closed (tracking) while s_clk is high, otherwise the held sample.
  assign vin_eff = s_clk ? vin : held_code;
  assign cmp_lhs = $signed({2'b00, vin_eff}) + OFFSET_S + noise;
  assign exp_sum = $signed({2'b00, held_code}) + OFFSET_S;

  // Reset-phase comparator: decision only visible while cmp_clk is high.
  assign cmp_out = cmp_clk & cmp_q;

  // Ideal final code is the held sample shifted by offset, clamped to range.
  always_comb begin
    expected = exp_sum[SAR_BITS-1:0];
    if (exp_sum < 10'sd0)        expected = '0;
    else if (exp_sum > 10'sd255) expected = '1;
  end

`ifdef AFE_NOISE_EN
  logic [1:0]        noise_bits;
  logic signed [9:0] code_diff;

  sar_noise_lfsr u_noise (
    .clk        (clk),
    .rst        (rst),
    .noise_bits (noise_bits)
  );

  // Map two LFSR bits to -1/0/+1 LSB of comparator noise.
  always_comb begin
    noise = 10'sd0;
    case (noise_bits)
      2'b00:   noise = -10'sd1;
      2'b11:   noise = 10'sd1;
      default: noise = 10'sd0;
    endcase
  end

  assign code_diff = $signed({2'b00, dac_code}) - $signed({2'b00, expected});
  assign match     = (code_diff >= -10'sd1) && (code_diff <= 10'sd1);
`else
  assign noise = 10'sd0;
  assign match = (dac_code == expected);
`endif

  // Edge strobes, comparator register and the sequencing FSM.
  // Event priority inside a state: s_clk rise > eoc > cmp_clk rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d          <= 1'b0;
      cmp_d        <= 1'b0;
      cmp_q        <= 1'b0;
      cmp_cnt      <= 4'd0;
      held_code    <= '0;
      conv_done    <= 1'b0;
      conv_ok      <= 1'b0;
      conv_count   <= '0;
      err_seq      <= 1'b0;
      err_mismatch <= 1'b0;
      state        <= S_IDLE;
    end else begin
      s_d       <= s_clk;
      cmp_d     <= cmp_clk;
      cmp_q     <= (cmp_lhs >= $signed({2'b00, dac_code}));
      conv_done <= 1'b0;
      // Clearing first; any error raised below overrides the clear.
      err_seq      <= err_seq & ~clr_err;
      err_mismatch <= err_mismatch & ~clr_err;
      case (state)
        S_IDLE: begin
          if (s_rise)              state <= S_TRACK;
          else if (eoc | cmp_rise) err_seq <= 1'b1;
        end
        S_TRACK: begin
          if (s_fall) begin
            held_code <= vin;
            cmp_cnt   <= 4'd0;
            state     <= S_HOLD;
          end
          if (cmp_rise) err_seq <= 1'b1;
        end
        S_HOLD: begin
          if (s_rise) begin
            err_seq <= 1'b1;
            state   <= S_TRACK;
          end else if (eoc) begin
            if (cmp_cnt == 4'd8) begin
              state <= S_CHECK;
            end else begin
              err_seq <= 1'b1;
              state   <= S_IDLE;
            end
          end else if (cmp_rise) begin
            if (cmp_cnt >= 4'd8)  err_seq <= 1'b1;
            if (cmp_cnt != 4'd15) cmp_cnt <= cmp_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          conv_done <= 1'b1;
          conv_ok   <= match;
          if (match) conv_count   <= conv_count + CNT_W'(1);
          else       err_mismatch <= 1'b1;
          state <= s_rise ? S_TRACK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_afe_emulator.sv
// Directed bench for sar_afe_emulator: a behavioural SAR controller closes the
// loop around an OFFSET=0 instance and an OFFSET=3 instance sharing stimulus.
module tb_sar_afe_emulator;
  import sar_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vin = 8'h00;
  logic       s_clk = 1'b0;
  logic       cmp_clk = 1'b0;
  logic [7:0] dac_code = 8'h00;
  logic       eoc = 1'b0;
  logic       clr_err = 1'b0;

  logic        cmp_out0, conv_done0, conv_ok0, err_seq0, err_mm0;
  logic [7:0]  held0;
  logic [15:0] count0;
  state_t      st0;

  logic        cmp_out1, conv_done1, conv_ok1, err_seq1, err_mm1;
  logic [7:0]  held1;
  logic [15:0] count1;
  state_t      st1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  sar_afe_emulator #(.OFFSET(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .vin(vin), .s_clk(s_clk), .cmp_clk(cmp_clk),
    .dac_code(dac_code), .eoc(eoc), .clr_err(clr_err), .cmp_out(cmp_out0),
    .held_code(held0), .conv_done(conv_done0), .conv_ok(conv_ok0),
    .conv_count(count0), .err_seq(err_seq0), .err_mismatch(err_mm0),
    .state(st0)
  );

  sar_afe_emulator #(.OFFSET(3), .CNT_W(16)) dut_off (
    .clk(clk), .rst(rst), .vin(vin), .s_clk(s_clk), .cmp_clk(cmp_clk),
    .dac_code(dac_code), .eoc(eoc), .clr_err(clr_err), .cmp_out(cmp_out1),
    .held_code(held1), .conv_done(conv_done1), .conv_ok(conv_ok1),
    .conv_count(count1), .err_seq(err_seq1), .err_mismatch(err_mm1),
    .state(st1)
  );

  // Clock and conv_done pulse counter for the OFFSET=0 instance.
  always #5 clk = ~clk;
  always @(posedge clk) if (conv_done0) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; s_clk = 1'b0; cmp_clk = 1'b0; eoc = 1'b0;
    clr_err = 1'b0; dac_code = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic track(input logic [7:0] v);
    vin = v;
    s_clk = 1'b1;
    repeat (3) @(negedge clk);
    s_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic trial_bits(input int sel, input int nbits, output logic [7:0] res);
    logic [7:0] t;
    logic       d;
    res = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      t = res | (8'h80 >> i);
      dac_code = t;
      @(negedge clk);
      cmp_clk = 1'b1;
      #1 d = (sel != 0) ? cmp_out1 : cmp_out0;
      @(negedge clk);
      cmp_clk = 1'b0;
      if (d) res = t;
    end
  endtask

  // Present final code with eoc; returns at the cycle conv_done is visible.
  task automatic end_conv(input logic [7:0] code);
    dac_code = code;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (st0 !== S_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", st0, S_IDLE); end
    n_checks++; if (held0 !== 8'h00) begin n_errors++; $display("FAIL reset_held: got %h expected 00", held0); end
    n_checks++; if ({conv_done0, conv_ok0, err_seq0, err_mm0, cmp_out0} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 00000", {conv_done0, conv_ok0, err_seq0, err_mm0, cmp_out0}); end
    n_checks++; if (count0 !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count0); end
  endtask

  task automatic test_closed_loop();
    logic [7:0] r;
    do_reset();
    track(8'hA5);
    n_checks++; if (held0 !== 8'hA5) begin n_errors++; $display("FAIL cl_held: got %h expected a5", held0); end
    n_checks++; if (st0 !== S_HOLD) begin n_errors++; $display("FAIL cl_hold_state: got %0d expected %0d", st0, S_HOLD); end
    trial_bits(0, 8, r);
    n_checks++; if (r !== 8'hA5) begin n_errors++; $display("FAIL cl_code: got %h expected a5", r); end
    end_conv(r);
    n_checks++; if (conv_done0 !== 1'b1) begin n_errors++; $display("FAIL cl_done: got %b expected 1", conv_done0); end
    n_checks++; if (conv_ok0 !== 1'b1) begin n_errors++; $display("FAIL cl_ok: got %b expected 1", conv_ok0); end
    n_checks++; if (count0 !== 16'd1) begin n_errors++; $display("FAIL cl_count: got %0d expected 1", count0); end
    n_checks++; if ({err_seq0, err_mm0} !== 2'b00) begin n_errors++; $display("FAIL cl_errs: got %b expected 00", {err_seq0, err_mm0}); end
    @(negedge clk);
    n_checks++; if (conv_done0 !== 1'b0) begin n_errors++; $display("FAIL cl_done_pulse: got %b expected 0", conv_done0); end
    n_checks++; if (conv_ok0 !== 1'b1) begin n_errors++; $display("FAIL cl_ok_hold: got %b expected 1", conv_ok0); end
  endtask

  task automatic test_boundaries();
    logic [7:0] r;
    do_reset();
    track(8'h00); trial_bits(0, 8, r);
    n_checks++; if (r !== 8'h00) begin n_errors++; $display("FAIL bnd_code_00: got %h expected 00", r); end
    end_conv(r);
    n_checks++; if (conv_ok0 !== 1'b1) begin n_errors++; $display("FAIL bnd_ok_00: got %b expected 1", conv_ok0); end
    repeat (2) @(negedge clk);
    track(8'hFF); trial_bits(0, 8, r);
    n_checks++; if (r !== 8'hFF) begin n_errors++; $display("FAIL bnd_code_ff: got %h expected ff", r); end
    end_conv(r);
    n_checks++; if (conv_ok0 !== 1'b1) begin n_errors++; $display("FAIL bnd_ok_ff: got %b expected 1", conv_ok0); end
    n_checks++; if (count0 !== 16'd2) begin n_errors++; $display("FAIL bnd_count: got %0d expected 2", count0); end
  endtask

  task automatic test_offset_clamp();
    logic [7:0] r;
    do_reset();
    track(8'hFE); trial_bits(1, 8, r);
    n_checks++; if (r !== 8'hFF) begin n_errors++; $display("FAIL off_code: got %h expected ff", r); end
    end_conv(r);
    n_checks++; if (conv_done1 !== 1'b1) begin n_errors++; $display("FAIL off_done: got %b expected 1", conv_done1); end
    n_checks++; if (conv_ok1 !== 1'b1) begin n_errors++; $display("FAIL off_ok: got %b expected 1", conv_ok1); end
    n_checks++; if (err_mm1 !== 1'b0) begin n_errors++; $display("FAIL off_mismatch: got %b expected 0", err_mm1); end
    // Same final code on the zero-offset twin is one LSB high: must mismatch.
    n_checks++; if (conv_ok0 !== 1'b0) begin n_errors++; $display("FAIL off_twin_ok: got %b expected 0", conv_ok0); end
  endtask

  task automatic test_idle_cmp();
    do_reset();
    cmp_clk = 1'b1; @(negedge clk); cmp_clk = 1'b0; @(negedge clk);
    n_checks++; if (err_seq0 !== 1'b1) begin n_errors++; $display("FAIL idle_cmp_err: got %b expected 1", err_seq0); end
    n_checks++; if (st0 !== S_IDLE) begin n_errors++; $display("FAIL idle_cmp_state: got %0d expected %0d", st0, S_IDLE); end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    n_checks++; if (err_seq0 !== 1'b0) begin n_errors++; $display("FAIL idle_clr: got %b expected 0", err_seq0); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int d0;
    do_reset();
    d0 = done_cnt;
    track(8'h33); trial_bits(0, 4, r);
    s_clk = 1'b1;
    @(negedge clk);
    n_checks++; if (err_seq0 !== 1'b1) begin n_errors++; $display("FAIL abort_err: got %b expected 1", err_seq0); end
    n_checks++; if (st0 !== S_TRACK) begin n_errors++; $display("FAIL abort_state: got %0d expected %0d", st0, S_TRACK); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== d0) begin n_errors++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
    track(8'h33); trial_bits(0, 8, r);
    end_conv(r);
    n_checks++; if (conv_ok0 !== 1'b1) begin n_errors++; $display("FAIL abort_next_ok: got %b expected 1", conv_ok0); end
    n_checks++; if (count0 !== 16'd1) begin n_errors++; $display("FAIL abort_next_count: got %0d expected 1", count0); end
  endtask

  task automatic test_mismatch_and_reset();
    logic [7:0] r;
    int d0;
    do_reset();
    track(8'h40); trial_bits(0, 8, r);
    end_conv(8'h00);
    n_checks++; if (conv_done0 !== 1'b1) begin n_errors++; $display("FAIL mm_done: got %b expected 1", conv_done0); end
    n_checks++; if (conv_ok0 !== 1'b0) begin n_errors++; $display("FAIL mm_ok: got %b expected 0", conv_ok0); end
    n_checks++; if (err_mm0 !== 1'b1) begin n_errors++; $display("FAIL mm_flag: got %b expected 1", err_mm0); end
    n_checks++; if (count0 !== 16'd0) begin n_errors++; $display("FAIL mm_count: got %0d expected 0", count0); end
    n_checks++; if (held0 !== 8'h40) begin n_errors++; $display("FAIL mm_held: got %h expected 40", held0); end
    repeat (2) @(negedge clk);
    track(8'h77); trial_bits(0, 3, r);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({cmp_out0, conv_done0, conv_ok0, err_seq0, err_mm0} !== 5'b0) begin
      n_errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {cmp_out0, conv_done0, conv_ok0, err_seq0, err_mm0}); end
    n_checks++; if (held0 !== 8'h00 || count0 !== 16'd0) begin
      n_errors++; $display("FAIL rst_mid_data: got held %h count %0d expected 00 0", held0, count0); end
    n_checks++; if (st0 !== S_IDLE) begin n_errors++; $display("FAIL rst_mid_state: got %0d expected %0d", st0, S_IDLE); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt !== d0 || err_seq0 !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_after: got done %0d err %b expected %0d 0", done_cnt, err_seq0, d0); end
  endtask

  initial begin
    test_reset();
    test_closed_loop();
    test_boundaries();
    test_offset_clamp();
    test_idle_cmp();
    test_abort();
    test_mismatch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
